// File: rtl/countdown_timer_bcd_pkg.sv
// Shared definitions for the MM:SS countdown/stopwatch timer.
//   state_t      : controller states (IDLE, PAUSE, RUN, EXPIRED), 2-bit encoding
//   sat_u        : clamp an unsigned value to a ceiling
//   bin_to_bcd2  : convert a binary value 0..99 into two packed BCD digits {tens, ones}
package countdown_timer_bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAUSE   = 2'd1,
    ST_RUN     = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  function automatic logic [6:0] sat_u(input logic [6:0] v, input logic [6:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  // Input must already be saturated to 0..99 so both digits fit in 4 bits.
  function automatic logic [7:0] bin_to_bcd2(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

endpackage

// File: rtl/countdown_timer_bcd_digit.sv
// One BCD digit of the timer chain.
//   clk_100MHz : clock
//   reset_n    : synchronous active-low reset, clears the digit
//   load       : capture load_val (overrides counting)
//   load_val   : BCD value to load
//   en         : advance one step this cycle
//   up         : 1 = increment, 0 = decrement
//   digit      : current value, 0..MODULUS-1
//   carry      : carry (up) or borrow (down) into the next digit: en while at the wrap point
module bcd_digit #(
  parameter int MODULUS = 10
) (
  input  logic       clk_100MHz,
  input  logic       reset_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  input  logic       up,
  output logic [3:0] digit,
  output logic       carry
);

  localparam logic [3:0] TOP = 4'(MODULUS - 1);

  always_ff @(posedge clk_100MHz) begin
    if (!reset_n) begin
      digit <= 4'd0;
    end else if (load) begin
      digit <= load_val;
    end else if (en) begin
      if (up) digit <= (digit == TOP)  ? 4'd0 : digit + 4'd1;
      else    digit <= (digit == 4'd0) ? TOP  : digit - 4'd1;
    end
  end

  assign carry = en && (up ? (digit == TOP) : (digit == 4'd0));

endmodule

// File: rtl/countdown_timer_bcd.sv
// MM:SS timer with loadable start value, down/up mode latched at load,
// pause/resume, a one-cycle done pulse and an expired level.
//   clk_100MHz                : sole clock; seconds derived by an internal divider
//   reset_n                   : synchronous active-low reset
//   load                      : 1-cycle pulse, captures start_minutes/start_seconds/mode
//   start_minutes/seconds     : binary start value, saturated to MAX_MINUTES / 59
//   mode                      : 0 = count down, 1 = count up (sampled on load only)
//   run                       : level, 1 = count, 0 = pause
//   sec_ones..min_tens        : BCD display digits
//   running / done / expired  : RUN state, entry pulse into EXPIRED, EXPIRED level
module countdown_timer_bcd
  import countdown_timer_bcd_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int TICK_HZ     = 1,
  parameter int MAX_MINUTES = 99
) (
  input  logic       clk_100MHz,
  input  logic       reset_n,
  input  logic       load,
  input  logic [6:0] start_minutes,
  input  logic [5:0] start_seconds,
  input  logic       mode,
  input  logic       run,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       done,
  output logic       expired
);

  localparam int             DIV      = CLK_HZ / TICK_HZ;
  localparam int             DIV_W    = $clog2(DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [3:0]     MAX_T    = 4'(MAX_MINUTES / 10);
  localparam logic [3:0]     MAX_O    = 4'(MAX_MINUTES % 10);

  state_t           state, state_d;
  logic [DIV_W-1:0] div;
  logic             mode_q;
  logic             done_q;
  logic [7:0]       min_bcd, sec_bcd;
  logic             tick, step, at_term, pre_term, min_at_max, min_zero;
  logic             c_so, c_st, c_mo, min_tens_carry_unused;

  assign min_bcd = bin_to_bcd2(sat_u(start_minutes, 7'(MAX_MINUTES)));
  assign sec_bcd = bin_to_bcd2(sat_u({1'b0, start_seconds}, 7'd59));

  // Terminal detection on the displayed digits. pre_term is the value one
  // tick away from terminal, so the tick that lands there also expires.
  // Up-mode counting never passes MAX_MINUTES:59, which caps the minutes.
  assign min_at_max = (min_tens == MAX_T) && (min_ones == MAX_O);
  assign min_zero   = (min_tens == 4'd0) && (min_ones == 4'd0);
  assign at_term    = mode_q ? (min_at_max && sec_tens == 4'd5 && sec_ones == 4'd9)
                             : (min_zero && sec_tens == 4'd0 && sec_ones == 4'd0);
  assign pre_term   = mode_q ? (min_at_max && sec_tens == 4'd5 && sec_ones == 4'd8)
                             : (min_zero && sec_tens == 4'd0 && sec_ones == 4'd1);

  assign tick = (div == DIV_LAST);
  assign step = (state == ST_RUN) && tick && !at_term && !load;

  always_comb begin
    state_d = state;
    if (load) begin
      state_d = ST_PAUSE;
    end else begin
      case (state)
        ST_PAUSE: if (run) state_d = ST_RUN;
        ST_RUN: begin
          if (at_term || (tick && pre_term)) state_d = ST_EXPIRED;
          else if (!run)                     state_d = ST_PAUSE;
        end
        default: state_d = state;
      endcase
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      div    <= '0;
      mode_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_d;
      done_q <= (state_d == ST_EXPIRED) && (state != ST_EXPIRED);
      if (load) begin
        div    <= '0;
        mode_q <= mode;
      end else if (state == ST_RUN) begin
        // Divider only advances in RUN so a pause keeps the partial second.
        div <= tick ? '0 : div + DIV_W'(1);
      end
    end
  end

  assign running = (state == ST_RUN);
  assign expired = (state == ST_EXPIRED);
  assign done    = done_q;

  bcd_digit #(.MODULUS(10)) u_sec_ones (
    .clk_100MHz(clk_100MHz), .reset_n(reset_n), .load(load), .load_val(sec_bcd[3:0]),
    .en(step), .up(mode_q), .digit(sec_ones), .carry(c_so)
  );

  bcd_digit #(.MODULUS(6)) u_sec_tens (
    .clk_100MHz(clk_100MHz), .reset_n(reset_n), .load(load), .load_val(sec_bcd[7:4]),
    .en(c_so), .up(mode_q), .digit(sec_tens), .carry(c_st)
  );

  bcd_digit #(.MODULUS(10)) u_min_ones (
    .clk_100MHz(clk_100MHz), .reset_n(reset_n), .load(load), .load_val(min_bcd[3:0]),
    .en(c_st), .up(mode_q), .digit(min_ones), .carry(c_mo)
  );

  bcd_digit #(.MODULUS(10)) u_min_tens (
    .clk_100MHz(clk_100MHz), .reset_n(reset_n), .load(load), .load_val(min_bcd[7:4]),
    .en(c_mo), .up(mode_q), .digit(min_tens), .carry(min_tens_carry_unused)
  );

endmodule
